// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan controller.
//   DIG_W        width of one display code (bit4 = decimal point, bits3:0 = hex)
//   DIG_ZERO     code treated as a suppressible leading zero
//   DIG_DP_BIT   position of the decimal-point bit inside a code
//   scan_state_t per-slot phase: DEAD (all commons off) then ON
package led_pkg;

  localparam int           DIG_W      = 5;
  localparam logic [4:0]   DIG_ZERO   = 5'h00;
  localparam int           DIG_DP_BIT = 4;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/led_lz_mask.sv
// Leading-zero blank vector for the digit buffer (purely combinational).
// Digit i is blanked when it and every digit above it hold DIG_ZERO.
// Digit 0 is never blanked. A code with only the decimal point set ("0.")
// is not zero, so it stops suppression for itself and everything below.
// Ports:
//   dbuf   in   NUM_DIGITS x DIG_W  display codes, index 0 = least significant
//   blank  out  NUM_DIGITS          1 = hold this digit's common off
module led_lz_mask
  import led_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic [NUM_DIGITS-1:0][DIG_W-1:0] dbuf,
  output logic [NUM_DIGITS-1:0]            blank
);

  logic zero_above;

  // Walk down from the most significant digit; suppression stops at the
  // first non-zero code and never reaches digit 0.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      zero_above = zero_above && (dbuf[i] == DIG_ZERO);
      blank[i]   = zero_above;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits that
// share one segment decoder. A host writes 5-bit codes into a per-digit
// buffer; the scanner walks the digits one slot at a time, loading the code
// for the slot into o_dig_ctrl during a dead-time with all commons off, then
// pulling that digit's active-low common low for the rest of the slot.
//
// Optional feature: define LED_LZ_BLANK_EN to enable leading-zero blanking
// (led_lz_mask). Without it, no blanking logic is built.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   wr_en         in   buffer write strobe
//   wr_idx        in   digit index to write (out-of-range indices ignored)
//   wr_data       in   display code to write
//   dig_mask      in   1 = digit enabled, sampled every cycle
//   o_dig_ctrl    out  code for the decoder, registered, stable for a slot
//   o_dig_com     out  active-low commons, at most one low, registered
//   o_frame_done  out  one-cycle pulse on the first cycle of slot 0 that
//                      follows the last slot of a frame
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int SCAN_DIV   = 50000,
  parameter  int DEAD_CYC   = 16,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int CNT_W      = $clog2(SCAN_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DIG_W-1:0]      wr_data,
  input  logic [NUM_DIGITS-1:0] dig_mask,
  output logic [DIG_W-1:0]      o_dig_ctrl,
  output logic [NUM_DIGITS-1:0] o_dig_com,
  output logic                  o_frame_done
);

  localparam logic [IDX_W:0]   NUM_D    = (IDX_W+1)'(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS-1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV-1);
  localparam logic [CNT_W-1:0] ON_CNT   = CNT_W'(DEAD_CYC);

  // cnt_q / idx_q / state_q describe the cycle currently visible on the
  // outputs; every registered output is computed from the *_n values so
  // that counter and outputs stay cycle-aligned.
  logic [CNT_W-1:0]                 cnt_q, cnt_n;
  logic [IDX_W-1:0]                 idx_q, idx_n;
  scan_state_t                      state_q, state_n;
  logic [NUM_DIGITS-1:0][DIG_W-1:0] dbuf_q, dbuf_n;
  logic                             slot_end;
  logic                             wr_ok;
  logic                             blank_cur;

  logic [DIG_W-1:0]                 ctrl_n;
  logic [NUM_DIGITS-1:0]            com_n;
  logic                             fd_n;

  // ---------------------------------------------------------------------
  // Slot counter, digit index and buffer write view
  // ---------------------------------------------------------------------
  assign slot_end = (cnt_q == LAST_CNT);
  assign wr_ok    = wr_en && ({1'b0, wr_idx} < NUM_D);

  always_comb begin
    cnt_n = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_n = idx_q;
    if (slot_end)
      idx_n = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  end

  // Buffer as it will be after this cycle's write; reading the slot load
  // from here gives the write-vs-load bypass for free.
  always_comb begin
    dbuf_n = dbuf_q;
    if (wr_ok)
      dbuf_n[wr_idx] = wr_data;
  end

`ifdef LED_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_v, blank_q;

  led_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .dbuf  (dbuf_n),
    .blank (blank_v)
  );

  // Blanking is frozen at slot start. The reset value matches an all-zero
  // buffer, which is what slot 0 after reset is displaying.
  always_ff @(posedge clk) begin
    if (rst)
      blank_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    else if (slot_end)
      blank_q <= blank_v;
  end

  // Only consulted while ON, which is at least one cycle into the slot,
  // so blank_q already holds this slot's vector.
  assign blank_cur = blank_q[idx_n];
`else
  assign blank_cur = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= DEAD;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      DEAD:    if (cnt_n == ON_CNT) state_n = ON;
      ON:      if (slot_end)        state_n = DEAD;
      default: state_n = DEAD;
    endcase
  end

  always_comb begin
    com_n  = '1;
    ctrl_n = o_dig_ctrl;
    fd_n   = 1'b0;
    if (state_n == ON && dig_mask[idx_n] && !blank_cur)
      com_n[idx_n] = 1'b0;
    // New code only enters on the first (dead) cycle of a slot.
    if (slot_end) begin
      ctrl_n = dbuf_n[idx_n];
      fd_n   = (idx_q == LAST_IDX);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      dbuf_q       <= '0;
      o_dig_ctrl   <= DIG_ZERO;
      o_dig_com    <= '1;
      o_frame_done <= 1'b0;
    end else begin
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      dbuf_q       <= dbuf_n;
      o_dig_ctrl   <= ctrl_n;
      o_dig_com    <= com_n;
      o_frame_done <= fd_n;
    end
  end

endmodule
